// File: rtl/pl_multiplier_pkg.sv
// Register offsets, control/status bit positions and FSM state types shared by
// the PL multiplier AXI4-Lite slave and its shift-add engine.
package pl_multiplier_pkg;

    localparam logic [4:0] ADDR_OP_A    = 5'h00;
    localparam logic [4:0] ADDR_OP_B    = 5'h04;
    localparam logic [4:0] ADDR_CTRL    = 5'h08;
    localparam logic [4:0] ADDR_STATUS  = 5'h0C;
    localparam logic [4:0] ADDR_PROD_LO = 5'h10;
    localparam logic [4:0] ADDR_PROD_HI = 5'h14;
    localparam logic [4:0] ADDR_SCRATCH = 5'h18;
    localparam logic [4:0] ADDR_ID      = 5'h1C;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_DONE_BIT   = 1;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4D55_4C01;
    localparam logic [5:0]  MULT_ITERS       = 6'd32;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pl_mult_seq.sv
// Unsigned 32x32->64 MSB-first shift-add multiplier, one iteration per cycle.
// Operands are captured on start; the 32nd iteration loads product and pulses done.
module pl_mult_seq
    import pl_multiplier_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done_pulse,
    output logic [63:0] product
);

    logic [31:0] a_q, a_d, b_q, b_d;
    logic [63:0] acc_q, acc_d, prod_q, prod_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [63:0] acc_step;

    assign acc_step   = {acc_q[62:0], 1'b0} + (b_q[31] ? {32'd0, a_q} : 64'd0);
    assign done_pulse = busy_q && (cnt_q == 6'd1);
    assign busy       = busy_q;
    assign product    = prod_q;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            acc_d = acc_step;
            b_d   = {b_q[30:0], 1'b0};
            cnt_d = cnt_q - 6'd1;
            if (done_pulse) begin
                prod_d = acc_step;
                busy_d = 1'b0;
            end
        end else if (start) begin
            a_d    = a;
            b_d    = b;
            acc_d  = '0;
            cnt_d  = MULT_ITERS;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/pl_multiplier_axil_slave.sv
// AXI4-Lite register front end for the PL shift-add multiplier.
// Optional PL_MULT_IRQ_EN adds the irq port and the CTRL.IRQ_EN bit.
//
// state  | meaning
// W_IDLE | waiting for AW and W together; both accepted in one cycle
// W_RESP | BVALID held until BREADY
// R_IDLE | waiting for ARVALID; RDATA captured on accept
// R_DATA | RVALID/RDATA held until RREADY
module pl_multiplier_axil_slave
    import pl_multiplier_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] C_ID_VALUE         = ID_VALUE_DEFAULT
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
`ifdef PL_MULT_IRQ_EN
    ,
    output logic                            irq
`endif
);

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;
    logic        wr_en, rd_en;
    logic [4:0]  wr_off, rd_off;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, scratch_q, scratch_d;
    logic [31:0] rdata_q, rdata_d, rd_val;
    logic        irq_en_q, irq_en_d, done_q, done_d, start_q, start_d;
    logic        mult_busy, mult_done;
    logic [63:0] mult_prod;
    logic        unused_sig;

    assign unused_sig  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign wr_off      = {S_AXI_AWADDR[4:2], 2'b00};
    assign rd_off      = {S_AXI_ARADDR[4:2], 2'b00};
    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
    assign S_AXI_RDATA = rdata_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        r_state_d = r_state_q;
        case (w_state_q)
            W_IDLE:  if (S_AXI_AWVALID && S_AXI_WVALID) w_state_d = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        case (r_state_q)
            R_IDLE:  if (S_AXI_ARVALID) r_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_en         = ARESETN && (w_state_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
        rd_en         = ARESETN && (r_state_q == R_IDLE) && S_AXI_ARVALID;
        S_AXI_AWREADY = wr_en;
        S_AXI_WREADY  = wr_en;
        S_AXI_BVALID  = (w_state_q == W_RESP);
        S_AXI_ARREADY = rd_en;
        S_AXI_RVALID  = (r_state_q == R_DATA);
    end

    // START is only honoured when idle; a new START also retires a stale DONE.
    always_comb begin
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        scratch_d = scratch_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        start_d   = 1'b0;
        if (wr_en) begin
            case (wr_off)
                ADDR_OP_A:    op_a_d    = apply_wstrb(op_a_q, S_AXI_WDATA, S_AXI_WSTRB);
                ADDR_OP_B:    op_b_d    = apply_wstrb(op_b_q, S_AXI_WDATA, S_AXI_WSTRB);
                ADDR_SCRATCH: scratch_d = apply_wstrb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
                ADDR_CTRL: if (S_AXI_WSTRB[0]) begin
                    start_d = S_AXI_WDATA[CTRL_START_BIT] && !mult_busy;
`ifdef PL_MULT_IRQ_EN
                    irq_en_d = S_AXI_WDATA[CTRL_IRQ_EN_BIT];
`endif
                end
                ADDR_STATUS: if (S_AXI_WSTRB[0] && S_AXI_WDATA[STAT_DONE_BIT]) done_d = 1'b0;
                default: ;
            endcase
        end
        if (start_d)   done_d = 1'b0;
        if (mult_done) done_d = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        case (rd_off)
            ADDR_OP_A:    rd_val = op_a_q;
            ADDR_OP_B:    rd_val = op_b_q;
            ADDR_CTRL:    rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
            ADDR_STATUS: begin
                rd_val[STAT_BUSY_BIT] = mult_busy;
                rd_val[STAT_DONE_BIT] = done_q;
            end
            ADDR_PROD_LO: rd_val = mult_prod[31:0];
            ADDR_PROD_HI: rd_val = mult_prod[63:32];
            ADDR_SCRATCH: rd_val = scratch_q;
            ADDR_ID:      rd_val = C_ID_VALUE;
            default:      rd_val = '0;
        endcase
        rdata_d = rd_en ? rd_val : rdata_q;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            scratch_q <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            scratch_q <= scratch_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            start_q   <= start_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef PL_MULT_IRQ_EN
    logic irq_q;
    always_ff @(posedge ACLK) begin
        if (!ARESETN) irq_q <= 1'b0;
        else          irq_q <= done_q && irq_en_q;
    end
    assign irq = irq_q;
`endif

    pl_mult_seq u_mult (
        .clk        (ACLK),
        .rstn       (ARESETN),
        .start      (start_q),
        .a          (op_a_q),
        .b          (op_b_q),
        .busy       (mult_busy),
        .done_pulse (mult_done),
        .product    (mult_prod)
    );

endmodule

// File: tb/tb_pl_multiplier_axil_slave.sv
// Self-checking bench for pl_multiplier_axil_slave: AXI4-Lite register access,
// byte strobes, back-pressure, multiply timing and results, reset abort, optional irq.
`timescale 1ns/1ps
module tb_pl_multiplier_axil_slave;

    localparam logic [4:0] A_OPA  = 5'h00;
    localparam logic [4:0] A_OPB  = 5'h04;
    localparam logic [4:0] A_CTRL = 5'h08;
    localparam logic [4:0] A_STAT = 5'h0C;
    localparam logic [4:0] A_PLO  = 5'h10;
    localparam logic [4:0] A_PHI  = 5'h14;
    localparam logic [4:0] A_SCR  = 5'h18;
    localparam logic [4:0] A_ID   = 5'h1C;
`ifdef PL_MULT_IRQ_EN
    localparam logic [31:0] CTRL_RB = 32'h2;
`else
    localparam logic [31:0] CTRL_RB = 32'h0;
`endif

    logic        ACLK = 1'b0, ARESETN = 1'b0;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0, failures = 0, cyc = 0, last_wr_edge = 0;

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    pl_multiplier_axil_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
`ifdef PL_MULT_IRQ_EN
        , .irq(irq)
`endif
    );

    // Byte-merge reference: strobe bits expanded to a mask.
    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    // at_edge > 0 schedules the handshake on that clock edge; hold keeps BREADY low for that many cycles.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int at_edge, input int hold);
        int n;
        @(negedge ACLK);
        if (at_edge > 0) begin
            while (cyc < at_edge - 1) @(negedge ACLK);
            checks++;
            if (cyc != at_edge - 1) begin
                failures++;
                $display("FAIL write_sched: handshake edge %0d required %0d", cyc + 1, at_edge);
            end
        end
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1; bready = (hold == 0);
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge ACLK); #1; n++;
        end
        checks++;
        if (!(awready && wready)) begin
            failures++;
            $display("FAIL write_accept: addr=%h awready=%b wready=%b required 1/1", addr, awready, wready);
            awvalid = 0; wvalid = 0;
            return;
        end
        last_wr_edge = cyc + 1;
        @(posedge ACLK); #1;
        awvalid = 0; wvalid = 0;
        @(negedge ACLK);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            failures++;
            $display("FAIL write_resp: bvalid=%b bresp=%b required 1/00", bvalid, bresp);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00) begin
                failures++;
                $display("FAIL write_stall: bvalid=%b bresp=%b required 1/00", bvalid, bresp);
            end
        end
        bready = 1;
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [4:0] addr, input int at_edge, input int hold,
                            output logic [31:0] data);
        int n;
        data = '0;
        @(negedge ACLK);
        if (at_edge > 0) begin
            while (cyc < at_edge - 1) @(negedge ACLK);
            checks++;
            if (cyc != at_edge - 1) begin
                failures++;
                $display("FAIL read_sched: accept edge %0d required %0d", cyc + 1, at_edge);
            end
        end
        araddr = addr; arvalid = 1; rready = (hold == 0);
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge ACLK); #1; n++;
        end
        checks++;
        if (!arready) begin
            failures++;
            $display("FAIL read_accept: addr=%h arready=%b required 1", addr, arready);
            arvalid = 0;
            return;
        end
        @(posedge ACLK); #1;
        arvalid = 0;
        @(negedge ACLK);
        checks++;
        if (rvalid !== 1'b1 || rresp !== 2'b00) begin
            failures++;
            $display("FAIL read_resp: rvalid=%b rresp=%b required 1/00", rvalid, rresp);
        end
        data = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            checks++;
            if (rvalid !== 1'b1 || rdata !== data) begin
                failures++;
                $display("FAIL read_stall: rvalid=%b rdata=%h required 1/%h", rvalid, rdata, data);
            end
        end
        rready = 1;
        @(posedge ACLK); #1;
    endtask

    task automatic wait_done();
        logic [31:0] s;
        int n;
        s = '0;
        n = 0;
        while (!s[1] && n < 40) begin
            axi_read(A_STAT, 0, 0, s);
            n++;
        end
        checks++;
        if (!s[1]) begin
            failures++;
            $display("FAIL wait_done: STATUS=%h never showed DONE", s);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL %s: aw/w/b/ar/r=%b rdata=%h required 00000/0", tag,
                     {awready, wready, bvalid, arready, rvalid}, rdata);
        end
`ifdef PL_MULT_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL %s_irq: irq=%b required 0", tag, irq);
        end
`endif
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_v [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4D55_4C01};
        ARESETN = 0;
        repeat (3) @(negedge ACLK);
        check_idle_outputs("reset_outputs");
        ARESETN = 1;
        for (int i = 0; i < 8; i++) begin
            axi_read(5'(i * 4), 0, 0, d);
            checks++;
            if (d !== exp_v[i]) begin
                failures++;
                $display("FAIL reset_reg[%0h]: got %h required %h", i * 4, d, exp_v[i]);
            end
        end
    endtask

    task automatic test_basic_rw();
        logic [31:0] d;
        logic [4:0]  addrs [4] = '{A_OPA, A_OPB, A_CTRL, A_SCR};
        logic [31:0] exp_v [4];
        exp_v = '{32'h1, 32'h2, CTRL_RB, 32'h4};
        for (int i = 0; i < 4; i++) axi_write(addrs[i], 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], 0, 0, d);
            checks++;
            if (d !== exp_v[i]) begin
                failures++;
                $display("FAIL basic_rw[%h]: got %h required %h", addrs[i], d, exp_v[i]);
            end
        end
        wait_done();
        axi_read(A_PLO, 0, 0, d);
        checks++;
        if (d !== 32'd2) begin
            failures++;
            $display("FAIL basic_prod: got %h required 2", d);
        end
        axi_write(A_CTRL, 32'h0, 4'hF, 0, 0);
        axi_write(A_STAT, 32'h2, 4'hF, 0, 0);
    endtask

    task automatic test_full_mult_timing();
        logic [31:0] d;
        int e0;
        axi_write(A_OPA, 32'hFFFF_FFFF, 4'hF, 0, 0);
        axi_write(A_OPB, 32'hFFFF_FFFF, 4'hF, 0, 0);
        axi_write(A_CTRL, 32'h1, 4'hF, 0, 0);
        e0 = last_wr_edge;
        axi_read(A_STAT, e0 + 2, 0, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL busy_start: STATUS=%h required 1", d); end
        axi_read(A_STAT, e0 + 33, 0, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL busy_last: STATUS=%h required 1", d); end
        axi_read(A_STAT, e0 + 35, 0, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL done_status: STATUS=%h required 2", d); end
        axi_read(A_PHI, 0, 0, d);
        checks++;
        if (d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL max_prod_hi: got %h required fffffffe", d); end
        axi_read(A_PLO, 0, 0, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL max_prod_lo: got %h required 1", d); end
    endtask

    task automatic test_done_w1c_race();
        logic [31:0] d;
        int e0;
        axi_write(A_OPA, 32'd5, 4'hF, 0, 0);
        axi_write(A_OPB, 32'd5, 4'hF, 0, 0);
        axi_write(A_CTRL, 32'h1, 4'hF, 0, 0);
        e0 = last_wr_edge;
        axi_write(A_STAT, 32'h2, 4'hF, e0 + 33, 0);
        axi_read(A_STAT, 0, 0, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL done_set_wins: STATUS=%h required 2", d); end
        axi_write(A_STAT, 32'h2, 4'hF, 0, 0);
        axi_read(A_STAT, 0, 0, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL done_w1c: STATUS=%h required 0", d); end
        axi_read(A_PLO, 0, 0, d);
        checks++;
        if (d !== 32'd25) begin failures++; $display("FAIL race_prod: got %h required 25", d); end
    endtask

    task automatic test_wstrb();
        logic [31:0] d, model, v;
        logic [3:0]  s;
        axi_write(A_SCR, 32'h0, 4'hF, 0, 0);
        axi_write(A_SCR, 32'hAABB_CCDD, 4'b0101, 0, 0);
        axi_read(A_SCR, 0, 0, d);
        checks++;
        if (d !== 32'h00BB_00DD) begin failures++; $display("FAIL wstrb_fixed: got %h required 00bb00dd", d); end
        model = 32'h00BB_00DD;
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            s = 4'($urandom_range(0, 15));
            model = merge(model, v, s);
            axi_write(A_SCR, v, s, 0, 0);
            axi_read(A_SCR, 0, 0, d);
            checks++;
            if (d !== model) begin
                failures++;
                $display("FAIL wstrb_rand: strb=%b got %h required %h", s, d, model);
            end
        end
        axi_write(A_ID, 32'h1234_5678, 4'hF, 0, 0);
        axi_read(A_ID, 0, 0, d);
        checks++;
        if (d !== 32'h4D55_4C01) begin failures++; $display("FAIL ro_write: ID=%h required 4d554c01", d); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] d, v;
        v = $urandom;
        axi_write(A_SCR, v, 4'hF, 0, 10);
        axi_read(A_SCR, 0, 10, d);
        checks++;
        if (d !== v) begin failures++; $display("FAIL stall_data: got %h required %h", d, v); end
        v = $urandom;
        @(negedge ACLK);
        awaddr = A_SCR; wdata = v; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (awready !== 1'b0 || wready !== 1'b0) begin
                failures++;
                $display("FAIL aw_only: awready=%b wready=%b required 0/0", awready, wready);
            end
            @(negedge ACLK);
        end
        wvalid = 1;
        #1;
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            failures++;
            $display("FAIL aw_w_join: awready=%b wready=%b required 1/1", awready, wready);
        end
        @(posedge ACLK); #1;
        awvalid = 0; wvalid = 0;
        @(negedge ACLK);
        checks++;
        if (bvalid !== 1'b1) begin failures++; $display("FAIL skew_bvalid: bvalid=%b required 1", bvalid); end
        @(posedge ACLK); #1;
        axi_read(A_SCR, 0, 0, d);
        checks++;
        if (d !== v) begin failures++; $display("FAIL skew_data: got %h required %h", d, v); end
    endtask

    task automatic test_mid_op();
        logic [31:0] d;
        axi_write(A_OPA, 32'd7, 4'hF, 0, 0);
        axi_write(A_OPB, 32'd6, 4'hF, 0, 0);
        axi_write(A_CTRL, 32'h3, 4'hF, 0, 0);
`ifdef PL_MULT_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_busy: irq=%b required 0", irq); end
`endif
        axi_write(A_OPA, 32'd9, 4'hF, 0, 0);
        axi_write(A_CTRL, 32'h3, 4'hF, 0, 0);
        wait_done();
        axi_read(A_PLO, 0, 0, d);
        checks++;
        if (d !== 32'd42) begin failures++; $display("FAIL latched_ops: got %0d required 42", d); end
`ifdef PL_MULT_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_done: irq=%b required 1", irq); end
`endif
        axi_write(A_CTRL, 32'h3, 4'hF, 0, 0);
        axi_read(A_STAT, 0, 0, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL restart_clears_done: STATUS=%h required 1", d); end
        wait_done();
        axi_read(A_PLO, 0, 0, d);
        checks++;
        if (d !== 32'd54) begin failures++; $display("FAIL restart_prod: got %0d required 54", d); end
        axi_write(A_STAT, 32'h2, 4'h1, 0, 0);
        axi_read(A_STAT, 0, 0, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL w1c_clear: STATUS=%h required 0", d); end
`ifdef PL_MULT_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_cleared: irq=%b required 0", irq); end
`endif
        axi_write(A_CTRL, 32'h0, 4'hF, 0, 0);
    endtask

    task automatic test_random_mult();
        logic [31:0] a, b, d;
        logic [63:0] p;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 32'h8000_0000 : $urandom;
            b = (i == 1) ? 32'h0 : $urandom;
            p = 64'(a) * 64'(b);
            axi_write(A_OPA, a, 4'hF, 0, 0);
            axi_write(A_OPB, b, 4'hF, 0, 0);
            axi_write(A_CTRL, 32'h1, 4'hF, 0, 0);
            wait_done();
            axi_read(A_PLO, 0, 0, d);
            checks++;
            if (d !== p[31:0]) begin failures++; $display("FAIL rand_lo: %h*%h got %h required %h", a, b, d, p[31:0]); end
            axi_read(A_PHI, 0, 0, d);
            checks++;
            if (d !== p[63:32]) begin failures++; $display("FAIL rand_hi: %h*%h got %h required %h", a, b, d, p[63:32]); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d;
        int e0;
        axi_write(A_OPA, $urandom | 32'h1, 4'hF, 0, 0);
        axi_write(A_OPB, $urandom | 32'h1, 4'hF, 0, 0);
        axi_write(A_CTRL, 32'h1, 4'hF, 0, 0);
        e0 = last_wr_edge;
        @(negedge ACLK);
        while (cyc < e0 + 10) @(negedge ACLK);
        ARESETN = 0;
        @(negedge ACLK);
        check_idle_outputs("midop_reset");
        ARESETN = 1;
        axi_read(A_STAT, 0, 0, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL abort_status: STATUS=%h required 0", d); end
        axi_read(A_PLO, 0, 0, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL abort_prod: got %h required 0", d); end
        axi_read(A_OPA, 0, 0, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL abort_opa: got %h required 0", d); end
        axi_write(A_OPA, 32'd3, 4'hF, 0, 0);
        axi_write(A_OPB, 32'd5, 4'hF, 0, 0);
        axi_write(A_CTRL, 32'h1, 4'hF, 0, 0);
        wait_done();
        axi_read(A_PLO, 0, 0, d);
        checks++;
        if (d !== 32'd15) begin failures++; $display("FAIL post_reset_prod: got %0d required 15", d); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_rw();
        test_full_mult_timing();
        test_done_w1c_race();
        test_wstrb();
        test_back_pressure();
        test_mid_op();
        test_random_mult();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pl_multiplier_axil_slave.md
# pl_multiplier_axil_slave

AXI4-Lite responder that fronts the programmable-logic multiplier: it terminates the PS/VIP master's single-beat register writes and reads, holds operand/control/status/result registers, and drives a 32-cycle sequential shift-add multiplier. It sits between the AXI interconnect (S00_AXI) and the multiplier datapath inside the multiplier IP.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers.
- C_ID_VALUE, 32'h4D55_4C01, constant returned at 0x1C.

Ports:
- ACLK  in  1  sole clock; all logic on the rising edge.
- ARESETN  in  1  synchronous, active-low reset.
- S_AXI_AWADDR  in  5  write address. S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32. S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1.
- S_AXI_BRESP  out  2  always 2'b00. S_AXI_BVALID / S_AXI_BREADY  out / in  1.
- S_AXI_ARADDR  in  5. S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1.
- S_AXI_RDATA  out  32. S_AXI_RRESP  out  2  always 2'b00. S_AXI_RVALID / S_AXI_RREADY  out / in  1.
- irq  out  1  level interrupt; present only with PL_MULT_IRQ_EN.

## Operation
- Register map (addr[1:0] ignored): 0x00 OP_A RW; 0x04 OP_B RW; 0x08 CTRL (bit0 START write-1 pulse, reads 0; bit1 IRQ_EN RW); 0x0C STATUS (bit0 BUSY RO, bit1 DONE sticky, write-1-to-clear); 0x10 PROD_LO RO; 0x14 PROD_HI RO; 0x18 SCRATCH RW; 0x1C ID RO. Unimplemented bits read 0. Writes to RO registers complete with OKAY and have no effect.
- RW registers update per WSTRB byte.
- Write FSM W_IDLE -> W_RESP: in W_IDLE, when AWVALID && WVALID, AWREADY and WREADY are pulsed high for one cycle together and the register is written. In W_RESP, BVALID is held until BREADY, then the FSM returns to W_IDLE. One write is outstanding at a time. AW without W, or W without AW, waits.
- Read FSM R_IDLE -> R_DATA: in R_IDLE, ARVALID pulses ARREADY for one cycle. RDATA is registered with the value at the accept edge. RVALID and RDATA are held stable until RREADY.
- Read and write channels are independent and may complete in the same cycle.
- Multiplier: unsigned 32x32 -> 64, MSB-first shift-add, one iteration per cycle. Operands are latched at START, so OP_A/OP_B may be rewritten while BUSY.
- START while BUSY is ignored.
- START while DONE=1 clears DONE and begins a new operation.

## Timing
- Reset (ARESETN=0 at an edge): all registers and PROD are 0; BUSY=0, DONE=0; AWREADY/WREADY/BVALID/ARREADY/RVALID=0; RDATA=0; irq=0; both FSMs return to IDLE.
- Reset mid-operation aborts the multiply and drops any pending response.
- Write-to-register effect: visible to a read accepted one cycle after the write handshake. Minimum write latency is handshake to BVALID in 1 cycle.
- Read latency: ARREADY at edge E, RVALID at E+1.
- START is accepted at handshake edge E0. BUSY=1 from E0+1. At edge E0+33, PROD_HI/LO are loaded, DONE=1 and BUSY=0.
- DONE set and a W1C to DONE in the same cycle: set wins.
- Continuous BREADY/RREADY=1 sustains one write per 2 cycles and one read per 2 cycles.

## Configuration
- PL_MULT_IRQ_EN defined: the irq port exists and irq = DONE && CTRL.IRQ_EN, registered, updating one cycle after either input changes.
- Undefined: there is no irq port, CTRL bit1 reads 0, and writes to it are ignored.

## Structure
- Package pl_multiplier_pkg holds:
  - register offset localparams (ADDR_OP_A ... ADDR_ID);
  - CTRL/STATUS bit-index constants;
  - typedef enums for the write FSM {W_IDLE, W_RESP} and the read FSM {R_IDLE, R_DATA};
  - C_ID_VALUE default.
- Sub-module pl_mult_seq contains the shift-add engine. Ports: clk, rstn, start, a[31:0], b[31:0], busy, done_pulse, product[63:0].

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x00/0x04/0x08/0x18, then read back. Expected: 0x1, 0x2, 0x2 (START reads 0, IRQ_EN=1), 0x4. BRESP/RRESP are OKAY.
- OP_A=0xFFFF_FFFF, OP_B=0xFFFF_FFFF, then START. Expected: BUSY=1 for 32 cycles, then PROD_HI=0xFFFF_FFFE, PROD_LO=0x0000_0001, STATUS=0x2.
- Write 0xAABBCCDD with WSTRB=4'b0101 to SCRATCH (previously 0). Expected readback 0x00BB00DD.
- Hold BREADY/RREADY low for 10 cycles. Expected: BVALID/RVALID and RDATA stay stable. AW and W presented 3 cycles apart are accepted only once both are valid.
- START with 7x6. Mid-operation, write OP_A=9 and issue a second START. Expected result 42, not 54. W1C STATUS=0x2 clears DONE. With PL_MULT_IRQ_EN, irq follows DONE.
- Assert ARESETN=0 at cycle 10 of a multiply. Expected: all outputs 0, and a subsequent 3x5 multiply yields 15.
